// File: rtl/norm_ctrl.sv
// Two-stage normalization controller: leading-zero count per lane, left-normalize
// the significands and adjust exponents, with valid/ready flow control on both sides.

module normalize #(
    parameter int W = 106
) (
    input  logic [W-1:0] i_sum,
    input  logic [6:0]   i_shtamt0,
    input  logic [6:0]   i_shtamt1,
    input  logic [6:0]   i_shtamt2,
    input  logic [6:0]   i_shtamt3,
    input  logic [1:0]   i_mode,
    output logic [W-1:0] o_sum
);

    logic [47:0] w_h0;
    logic [47:0] w_h1;
    logic [21:0] w_q0;
    logic [21:0] w_q1;
    logic [21:0] w_q2;
    logic [21:0] w_q3;

    // Each lane shifts inside its own field; gap bits between fields come out zero.
    always_comb begin
        w_h0 = i_sum[47:0]   << i_shtamt0;
        w_h1 = i_sum[105:58] << i_shtamt1;
        w_q0 = i_sum[21:0]   << i_shtamt0;
        w_q1 = i_sum[49:28]  << i_shtamt1;
        w_q2 = i_sum[77:56]  << i_shtamt2;
        w_q3 = i_sum[105:84] << i_shtamt3;
        case (i_mode)
            2'b10:   o_sum = {w_h1, 10'b0, w_h0};
            2'b01:   o_sum = {w_q3, 6'b0, w_q2, 6'b0, w_q1, 6'b0, w_q0};
            default: o_sum = i_sum << i_shtamt0;
        endcase
    end

endmodule

module norm_ctrl #(
    parameter int W  = 106,
    parameter int EW = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [W-1:0]    in_sum,
    input  logic [4*EW-1:0] in_exp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_mode,
    output logic [W-1:0]    out_sum,
    output logic [4*EW-1:0] out_exp,
    output logic [3:0]      out_zero
);

    // Fields are left-aligned before counting, so the result is zeros above the field MSB.
    function automatic logic [6:0] f_lzc(input logic [W-1:0] v);
        f_lzc = 7'd0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) f_lzc = 7'(W - 1 - i);
        end
    endfunction

    logic            r_s1_valid;
    logic [1:0]      r_s1_mode;
    logic [W-1:0]    r_s1_sum;
    logic [4*EW-1:0] r_s1_exp;
    logic [3:0][6:0] r_s1_lzc;
    logic [3:0]      r_s1_zero;

    logic            r_s2_valid;
    logic [1:0]      r_s2_mode;
    logic [W-1:0]    r_s2_sum;
    logic [4*EW-1:0] r_s2_exp;
    logic [3:0]      r_s2_zero;

    logic            w_adv1;
    logic            w_adv2;
    logic            w_accept;
    logic [1:0]      w_in_eff;
    logic [1:0]      w_s1_eff;
    logic [3:0]      w_s1_act;
    logic [3:0][6:0] w_lzc;
    logic [3:0]      w_zero;
    logic [W-1:0]    w_shift_out;
    logic [4*EW-1:0] w_exp_nxt;

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign w_accept = in_valid && w_adv1;
    assign in_ready = w_adv1;

    assign w_in_eff = (in_mode == 2'b11) ? 2'b00 : in_mode;
    assign w_s1_eff = (r_s1_mode == 2'b11) ? 2'b00 : r_s1_mode;

    always_comb begin
        w_lzc  = '0;
        w_zero = '0;
        case (w_in_eff)
            2'b10: begin
                w_lzc[0]  = f_lzc({in_sum[47:0], 58'b0});
                w_zero[0] = ~|in_sum[47:0];
                w_lzc[1]  = f_lzc({in_sum[105:58], 58'b0});
                w_zero[1] = ~|in_sum[105:58];
            end
            2'b01: begin
                for (int i = 0; i < 4; i++) begin
                    w_lzc[i]  = f_lzc({in_sum[28*i +: 22], 84'b0});
                    w_zero[i] = ~|in_sum[28*i +: 22];
                end
            end
            default: begin
                w_lzc[0]  = f_lzc(in_sum);
                w_zero[0] = ~|in_sum;
            end
        endcase
    end

    always_comb begin
        case (w_s1_eff)
            2'b10:   w_s1_act = 4'b0011;
            2'b01:   w_s1_act = 4'b1111;
            default: w_s1_act = 4'b0001;
        endcase
        w_exp_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_s1_act[i] && !r_s1_zero[i])
                w_exp_nxt[EW*i +: EW] = r_s1_exp[EW*i +: EW] - EW'(r_s1_lzc[i]);
        end
    end

    normalize #(.W(W)) u_normalize (
        .i_sum     (r_s1_sum),
        .i_shtamt0 (r_s1_lzc[0]),
        .i_shtamt1 (r_s1_lzc[1]),
        .i_shtamt2 (r_s1_lzc[2]),
        .i_shtamt3 (r_s1_lzc[3]),
        .i_mode    (w_s1_eff),
        .o_sum     (w_shift_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= '0;
            r_s1_sum   <= '0;
            r_s1_exp   <= '0;
            r_s1_lzc   <= '0;
            r_s1_zero  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_mode  <= '0;
            r_s2_sum   <= '0;
            r_s2_exp   <= '0;
            r_s2_zero  <= '0;
        end else begin
            if (w_adv1) r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_mode <= in_mode;
                r_s1_sum  <= in_sum;
                r_s1_exp  <= in_exp;
                r_s1_lzc  <= w_lzc;
                r_s1_zero <= w_zero;
            end
            if (w_adv2) r_s2_valid <= r_s1_valid;
            // Output data only moves when a real beat arrives, so a bubble keeps it quiet.
            if (w_adv2 && r_s1_valid) begin
                r_s2_mode <= r_s1_mode;
                r_s2_sum  <= w_shift_out;
                r_s2_exp  <= w_exp_nxt;
                r_s2_zero <= r_s1_zero;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_mode  = r_s2_mode;
    assign out_sum   = r_s2_sum;
    assign out_exp   = r_s2_exp;
    assign out_zero  = r_s2_zero;

endmodule

// File: doc/norm_ctrl.md
Name: norm_ctrl

Overview:
- Two-stage pipelined normalization controller for the multi-precision FMA adder output.
- Per lane, it computes the leading-zero count of the 106-bit sum vector, drives the shift amounts of an internal `normalize` shifter instance, and adjusts each lane exponent.
- It sits between the significand adder and the rounding stage, and exchanges data with both through a valid/ready handshake.

Parameters:
- W, 106, sum vector width (fixed by lane layout).
- EW, 13, per-lane exponent width (two's complement).

Ports:
- clk  in  1  clock, all state rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  controller can accept a beat.
- in_mode  in  2  00 = one 106-bit lane, 10 = two 48-bit lanes, 01 = four 22-bit lanes, 11 = treated as 00.
- in_sum  in  W  unnormalized significands.
- in_exp  in  4*EW  lane i exponent at [EW*i+EW-1:EW*i].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_mode  out  2  mode of the result beat.
- out_sum  out  W  normalized significands.
- out_exp  out  4*EW  adjusted exponents.
- out_zero  out  4  lane significand field was all zero.

Behaviour:
- Lane fields (bit ranges of in_sum):
  - mode 00: lane0 [105:0].
  - mode 10: lane0 [47:0], lane1 [105:58].
  - mode 01: lane i [28i+21:28i], i = 0..3.
  - Bits outside the fields are don't-care in and are forced 0 on out_sum.
- Stage 1 (register S1), on accept:
  - Latch mode, sum and exp.
  - Per active lane, latch lzc = count of zeros from the field MSB down to the first 1.
  - 7-bit lzc for mode 00; 6-bit values zero-extended for the others.
- All-zero field: lzc = 0, zero flag = 1, out_exp lane = 0.
- Inactive lanes: lzc = 0, zero = 0, out_exp lane = 0.
- Shifter connection:
  - The S1 registers drive the internal normalize instance: in = S1 sum, shtamt0..3 = S1 lzc lanes 0..3, mode = S1 mode.
  - For mode 11, pass mode 00 to the shifter.
- Stage 2 (register S2), on advance, latch:
  - shifter output;
  - exp_i - lzc_i, EW-bit modular subtraction (no saturation);
  - zero flags and mode.
  - S2 drives all out_* directly.
- Handshake:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational).
  - Accept occurs when in_valid & in_ready.
  - s1_valid <= accept when adv1.
  - s2_valid <= s1_valid when adv2.
  - out_valid = s2_valid.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Stall behaviour:
  - While out_valid & !out_ready, out_* hold stable.
  - S1 holds while full and S2 is stalled.
  - in_ready drops only when both stages are full and out_ready = 0.
  - Simultaneous S2 drain and S1 fill in the same cycle must not lose or duplicate beats.
- Reset (async, any time including mid-operation):
  - s1_valid = s2_valid = 0, out_valid = 0.
  - out_sum = 0, out_exp = 0, out_zero = 0, out_mode = 00.
  - in_ready = 1 after reset.
  - In-flight beats are discarded.
- Data registers do not change when their stage does not advance.

Test Plan:
- Mode 00, in_sum = 1<<100, in_exp lane0 = 1000, out_ready = 1.
  - Required: out_valid 2 cycles after accept, out_sum = 1<<105, out_exp lane0 = 995, out_zero = 0000.
- Mode 01, lane fields: lane0 = 22'h000001, lane1 = 22'h200000, lane2 = 0, lane3 = 22'h000800, all exps = 20.
  - Required shifts: 21, 0, 0, 10.
  - Required out_exp: -1 (13'h1FFF), 20, 0, 10.
  - Required out_zero = 0100.
  - Required: bits 22-27, 50-55 and 78-83 of out_sum are 0.
- Mode 10, lane0 = 48'h0000_0000_0F00, lane1 = 48'h8000_0000_0000, exps 50/50.
  - Required shifts: 36, 0.
  - Required out_exp: 14, 50.
  - Required: out_sum[57:48] = 0.
- Backpressure: stream 4 beats, out_ready = 0 for 3 cycles after the first out_valid.
  - Required: in_ready low exactly while both stages are full.
  - Required: all 4 results emerge in order, each held stable while stalled, with no drop or duplicate.
- Zero / mode 11: mode 00 all-zero sum, exp = 77 -> out_zero[0] = 1, out_exp = 0, out_sum = 0. Mode 11 with sum 1<<104 -> same result as mode 00, out_mode = 11.
- Reset mid-flight: assert rst_n low asynchronously with both stages full.
  - Required: out_valid falls immediately and all outputs go to 0.
  - Required: after release, in_ready = 1 and the first new beat appears 2 cycles after its accept.
